// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and divider-state definitions for the pipelined execute ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIVU = 4'd3;
    localparam logic [3:0] OP_REMU = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_DZ    = 4;
    localparam int FLG_W     = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, result held until acked.
module alu_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] quot_r, rem_r, div_r;
    logic             dz_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s, last_s;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        shift_s = {rem_r, quot_r[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, div_r});
        diff_s  = shift_s[WIDTH-1:0] - div_r;
        last_s  = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic; clr returns to IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = DIV_IDLE;
        end else begin
            case (state_r)
                DIV_IDLE: state_s = start ? DIV_RUN : DIV_IDLE;
                DIV_RUN:  state_s = last_s ? DIV_DONE : DIV_RUN;
                DIV_DONE: state_s = ack ? DIV_IDLE : DIV_DONE;
                default:  state_s = DIV_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= DIV_IDLE;
        else     state_r <= state_s;
    end

    // Operand load and shift/subtract datapath; b==0 falls out as all-ones / a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            quot_r <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
            dz_r   <= 1'b0;
        end else if (clr) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == DIV_IDLE && start) begin
            cnt_r  <= {CNT_W{1'b0}};
            quot_r <= a;
            rem_r  <= {WIDTH{1'b0}};
            div_r  <= b;
            dz_r   <= (b == {WIDTH{1'b0}});
        end else if (state_r == DIV_RUN) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            quot_r <= {quot_r[WIDTH-2:0], ge_s};
            rem_r  <= ge_s ? diff_s : shift_s[WIDTH-1:0];
        end
    end

    assign busy = (state_r != DIV_IDLE);
    assign done = (state_r == DIV_DONE);
    assign quot = quot_r;
    assign rem  = rem_r;
    assign dz   = dz_r;

endmodule

// File: rtl/alu_pipe_iter.sv
// Execute ALU: LAT-stage fast-op pipeline with valid/ready backpressure plus an
// iterative divider; results leave in acceptance order with their tag.
module alu_pipe_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [FLG_W-1:0] out_flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [LAT-1:0]   vld_r;
    logic [WIDTH-1:0] res_r [LAT];
    logic [TAG_W-1:0] tag_r [LAT];
    logic [FLG_W-1:0] flg_r [LAT];

    logic [3:0]       div_op_r;
    logic [TAG_W-1:0] div_tag_r;

    logic             stall_s, pipe_empty_s, accept_s, fast_acc_s, div_start_s;
    logic             div_busy_s, div_done_s, div_dz_s;
    logic [WIDTH-1:0] div_quot_s, div_rem_s, div_res_s;
    logic [WIDTH-1:0] fast_res_s, b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             fast_c_s, fast_v_s;
    logic [SH_W-1:0]  sh_s;

    function automatic logic [FLG_W-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                   input logic c, input logic v,
                                                   input logic z);
        logic [FLG_W-1:0] f;
        f            = {FLG_W{1'b0}};
        f[FLG_ZERO]  = (r == {WIDTH{1'b0}});
        f[FLG_NEG]   = r[WIDTH-1];
        f[FLG_CARRY] = c;
        f[FLG_OVF]   = v;
        f[FLG_DZ]    = z;
        return f;
    endfunction

    // Fast-op result; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        sh_s       = in_b[SH_W-1:0];
        b_eff_s    = (in_op == OP_SUB) ? ~in_b : in_b;
        sum_s      = {1'b0, in_a} + {1'b0, b_eff_s} + (WIDTH+1)'(in_op == OP_SUB);
        fast_res_s = {WIDTH{1'b0}};
        fast_c_s   = 1'b0;
        fast_v_s   = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                fast_res_s = sum_s[WIDTH-1:0];
                fast_c_s   = sum_s[WIDTH];
                fast_v_s   = (in_a[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                             (sum_s[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_MUL:  fast_res_s = in_a * in_b;
            OP_SLL:  fast_res_s = in_a << sh_s;
            OP_SRL:  fast_res_s = in_a >> sh_s;
            OP_SRA:  fast_res_s = $signed(in_a) >>> sh_s;
            OP_AND:  fast_res_s = in_a & in_b;
            OP_OR:   fast_res_s = in_a | in_b;
            OP_XOR:  fast_res_s = in_a ^ in_b;
            default: fast_res_s = {WIDTH{1'b0}};
        endcase
    end

    // A div waits for an empty pipe and nothing enters behind it, so order is kept.
    assign pipe_empty_s = (vld_r == {LAT{1'b0}});
    assign out_valid    = vld_r[LAT-1] | div_done_s;
    assign stall_s      = out_valid & ~out_ready;
    assign in_ready     = ~rst & ~flush & ~div_busy_s & ~stall_s &
                          (~is_div(in_op) | pipe_empty_s);
    assign accept_s     = in_valid & in_ready;
    assign div_start_s  = accept_s & is_div(in_op);
    assign fast_acc_s   = accept_s & ~is_div(in_op);

    // Fast-op shift pipeline; holds as a whole while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                res_r[i] <= {WIDTH{1'b0}};
                tag_r[i] <= {TAG_W{1'b0}};
                flg_r[i] <= {FLG_W{1'b0}};
            end
        end else if (flush) begin
            vld_r <= {LAT{1'b0}};
        end else if (!stall_s) begin
            vld_r[0] <= fast_acc_s;
            res_r[0] <= fast_res_s;
            tag_r[0] <= in_tag;
            flg_r[0] <= mk_flags(fast_res_s, fast_c_s, fast_v_s, 1'b0);
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                res_r[i] <= res_r[i-1];
                tag_r[i] <= tag_r[i-1];
                flg_r[i] <= flg_r[i-1];
            end
        end
    end

    // Opcode and tag of the op currently owned by the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_op_r  <= 4'd0;
            div_tag_r <= {TAG_W{1'b0}};
        end else if (div_start_s) begin
            div_op_r  <= in_op;
            div_tag_r <= in_tag;
        end
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .start (div_start_s),
        .a     (in_a),
        .b     (in_b),
        .ack   (div_done_s & out_ready),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .quot  (div_quot_s),
        .rem   (div_rem_s),
        .dz    (div_dz_s)
    );

    // Output select: divider result when done, else the last pipe stage.
    always_comb begin
        div_res_s = (div_op_r == OP_DIVU) ? div_quot_s : div_rem_s;
        if (div_done_s) begin
            out_result = div_res_s;
            out_tag    = div_tag_r;
            out_flags  = mk_flags(div_res_s, 1'b0, 1'b0, div_dz_s);
        end else begin
            out_result = res_r[LAT-1];
            out_tag    = tag_r[LAT-1];
            out_flags  = flg_r[LAT-1];
        end
    end

endmodule

// File: tb/tb_alu_pipe_iter.sv
// Scoreboard bench for alu_pipe_iter: directed corner cases plus randomized traffic
// against an arithmetic reference model.
module tb_alu_pipe_iter;

    localparam int WIDTH = 32;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;

    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_a = 32'd0, in_b = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [4:0]  out_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [4:0]  flg;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, cyc = 0, last_acc = -1;
    bit   rdy_rand = 1'b0, lat_chk = 1'b1;

    alu_pipe_iter #(.WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        longint      sr;
        logic        c, v, dz;
        logic [31:0] r;
        c = 1'b0; v = 1'b0; dz = 1'b0; r = 32'd0; sr = 64'sd0;
        case (op)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                c  = s[32];
                sr = longint'($signed(a)) + longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r  = a - b;
                c  = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            4'd3: begin dz = (b == 32'd0); r = dz ? 32'hFFFF_FFFF : a / b; end
            4'd4: begin dz = (b == 32'd0); r = dz ? a : a % b; end
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = a & b;
            4'd9: r = a | b;
            4'd10: r = a ^ b;
            default: r = 32'd0;
        endcase
        e.res = r;
        e.flg = {dz, v, c, r[31], (r == 32'd0)};
        e.tag = 4'd0;
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one op until accepted; push the expected response at acceptance.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input bit ovr = 1'b0,
                        input logic [31:0] xr = 32'd0, input logic [4:0] xf = 5'd0);
        exp_t e;
        bit   done = 1'b0;
        e = model(op, a, b);
        if (ovr) begin e.res = xr; e.flg = xf; end
        e.tag = tag;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done  = 1'b1;
                e.acc = cyc;
                e.lat = !lat_chk ? 0 : ((op == 4'd3 || op == 4'd4) ? WIDTH + 1 : LAT);
                sb.push_back(e);
                last_acc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() > 0; k++) cycles(1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every handshake; checks stall stability.
    initial begin
        exp_t        e;
        bit          pstall = 1'b0;
        logic [31:0] pres = 32'd0;
        logic [3:0]  ptag = 4'd0;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                    chk("stall_hold_result", {32'd0, out_result}, {32'd0, pres});
                    chk("stall_hold_tag", {60'd0, out_tag}, {60'd0, ptag});
                end
                if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", {32'd0, out_result}, {32'd0, e.res});
                        chk("tag", {60'd0, out_tag}, {60'd0, e.tag});
                        chk("flags", {59'd0, out_flags}, {59'd0, e.flg});
                        if (e.lat != 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                end
                pstall = out_valid && !out_ready;
                pres   = out_result;
                ptag   = out_tag;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          first, t0, fl_cyc;
        logic [3:0]  op;
        rst = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        send(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd1, 1'b1, 32'd0, 5'b00101);
        send(4'd1, 32'h8000_0000, 32'd1, 4'd2, 1'b1, 32'h7FFF_FFFF, 5'b01100);
        drain();

        send(4'd10, $urandom, $urandom, 4'd0);
        first = last_acc;
        for (int i = 1; i < 8; i++) send(4'd10, $urandom, $urandom, 4'(i));
        chk("b2b_accept", 64'(last_acc - first), 64'd7);
        drain();

        out_ready = 1'b0;
        lat_chk   = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send(4'd8, $urandom, $urandom, 4'(8 + i));
            end
            begin
                for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
                cycles(5);
                chk("bp_accepted_during_stall", 64'(sb.size()), 64'd2);
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        send(4'd3, 32'd100, 32'd7, 4'd3, 1'b1, 32'd14, 5'b00000);
        send(4'd4, 32'd100, 32'd7, 4'd4, 1'b1, 32'd2, 5'b00000);
        send(4'd3, 32'h0000_1234, 32'd0, 4'd5, 1'b1, 32'hFFFF_FFFF, 5'b10010);
        send(4'd4, 32'd5, 32'd0, 4'd6, 1'b1, 32'd5, 5'b10000);
        send(4'd3, $urandom, $urandom | 32'd1, 4'd7);
        t0 = last_acc;
        send(4'd0, 32'd3, 32'd4, 4'd8);
        chk("fast_waits_for_div", {63'd0, (last_acc - t0) >= WIDTH + 1}, 64'd1);
        drain();

        send(4'd3, 32'd1000, 32'd3, 4'd9);
        fl_cyc = 0;
        fork
            send(4'd0, 32'd10, 32'd20, 4'd10);
            begin
                cycles(4);
                flush = 1'b1;
                @(negedge clk);
                chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
                fl_cyc = cyc;
                sb.delete();
                @(posedge clk); #1;
                flush = 1'b0;
                @(negedge clk);
                chk("post_flush_out_valid", {63'd0, out_valid}, 64'd0);
            end
        join
        chk("accept_after_flush", 64'(last_acc), 64'(fl_cyc + 1));
        drain();

        send(4'd0, 32'd1, 32'd2, 4'd11);
        send(4'd2, 32'd3, 32'd5, 4'd12);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_release", {63'd0, in_ready}, 64'd1);
        cycles(5);

        rdy_rand = 1'b1;
        lat_chk  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 4)) : 4'($urandom_range(0, 15));
            send(op, pick(), pick(), 4'(i));
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
